// File: rtl/writeback_queue.sv
// writeback_queue: in-order buffer of pending register-file writes with two-port youngest-value forwarding lookup.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [ADDR_W-1:0]          inReg,
    input  logic [DATA_W-1:0]          inData,
    input  logic                       wbEnable,
    output logic                       RegWrite,
    output logic [ADDR_W-1:0]          writeReg,
    output logic [DATA_W-1:0]          writeData,
    input  logic [ADDR_W-1:0]          lookupReg1,
    input  logic [ADDR_W-1:0]          lookupReg2,
    output logic                       hit1,
    output logic [DATA_W-1:0]          hitData1,
    output logic                       hit2,
    output logic [DATA_W-1:0]          hitData2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] q_reg  [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     head, tail, idx;
    logic [CW-1:0]     cnt;
    logic              push, pop;

    assign count     = cnt;
    assign full      = cnt == CW'(DEPTH);
    assign empty     = cnt == '0;
    assign inReady   = !full;
    assign RegWrite  = !empty && wbEnable;
    assign writeReg  = empty ? '0 : q_reg[head];
    assign writeData = empty ? '0 : q_data[head];
    // Register 0 is hardwired, so such requests are acknowledged but dropped.
    assign push      = inValid && inReady && inReg != '0;
    assign pop       = RegWrite;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit1     = 1'b0;
        hitData1 = '0;
        hit2     = 1'b0;
        hitData2 = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && lookupReg1 != '0 && q_reg[idx] == lookupReg1) begin
                hit1     = 1'b1;
                hitData1 = q_data[idx];
            end
            if (valid[idx] && lookupReg2 != '0 && q_reg[idx] == lookupReg2) begin
                hit2     = 1'b1;
                hitData2 = q_data[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_reg[i]  <= '0;
                q_data[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                q_reg[tail]  <= inReg;
                q_data[tail] <= inData;
                valid[tail]  <= 1'b1;
                tail         <= tail + PW'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: table-driven vectors plus a commit-order scoreboard for writeback_queue.
module tb_writeback_queue;
    logic        clk, rst_n, flush, inValid, inReady, wbEnable, RegWrite;
    logic        hit1, hit2, full, empty;
    logic [4:0]  inReg, writeReg, lookupReg1, lookupReg2;
    logic [31:0] inData, writeData, hitData1, hitData2;
    logic [2:0]  count;
    int          checks = 0;
    int          errors = 0;
    logic [36:0] sb [$];

    typedef struct {
        logic        iv;
        logic [4:0]  ir;
        logic [31:0] id;
        logic        wb;
        logic [4:0]  l1, l2;
        int          cnt;
        logic        rw, h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;
    vec_t v [10];

    writeback_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .inValid(inValid), .inReady(inReady),
        .inReg(inReg), .inData(inData), .wbEnable(wbEnable), .RegWrite(RegWrite),
        .writeReg(writeReg), .writeData(writeData), .lookupReg1(lookupReg1),
        .lookupReg2(lookupReg2), .hit1(hit1), .hitData1(hitData1), .hit2(hit2),
        .hitData2(hitData2), .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample at the falling edge what the next rising edge will commit, then step past it.
    task automatic tick();
        logic [36:0] e;
        @(negedge clk);
        if (!rst_n) sb.delete();
        else begin
            if (RegWrite) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got reg %0d data %0h expected none", writeReg, writeData);
                end else begin
                    e = sb.pop_front();
                    chk("wb_reg", 64'(writeReg), 64'(e[36:32]));
                    chk("wb_data", 64'(writeData), 64'(e[31:0]));
                end
            end
            if (flush) sb.delete();
            else if (inValid && inReady && inReg != 5'd0) sb.push_back({inReg, inData});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [4:0] r, input logic [31:0] d);
        inValid = 1'b1;
        inReg   = r;
        inData  = d;
        tick();
        inValid = 1'b0;
    endtask

    task automatic drain();
        inValid  = 1'b0;
        wbEnable = 1'b1;
        for (int k = 0; k < 20 && !empty; k++) tick();
        chk("drain_empty", 64'(empty), 1);
        chk("drain_sb", 64'(sb.size()), 0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; inReg = '0; inData = '0;
        wbEnable = 1'b1; lookupReg1 = 5'd3; lookupReg2 = 5'd0;
        #1;
        chk("rst_count", 64'(count), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_full", 64'(full), 0);
        chk("rst_inready", 64'(inReady), 1);
        chk("rst_regwrite", 64'(RegWrite), 0);
        chk("rst_wdata", 64'(writeData), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        v[0] = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd3, 5'd0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        v[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3, 1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5};
        v[2] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd4, 1, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0};
        v[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd3, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        v[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        v[5] = '{1'b1, 5'd5, 32'h11, 1'b0, 5'd5, 5'd0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        v[6] = '{1'b1, 5'd5, 32'h22, 1'b0, 5'd5, 5'd0, 1, 1'b0, 1'b1, 32'h11, 1'b0, 32'h0};
        v[7] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd3, 2, 1'b1, 1'b1, 32'h22, 1'b0, 32'h0};
        v[8] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd5, 1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h22};
        v[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            inValid = v[i].iv; inReg = v[i].ir; inData = v[i].id; wbEnable = v[i].wb;
            lookupReg1 = v[i].l1; lookupReg2 = v[i].l2;
            #1;
            chk($sformatf("v%0d_count", i), 64'(count), 64'(v[i].cnt));
            chk($sformatf("v%0d_full", i), 64'(full), 64'(v[i].cnt == 4));
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(v[i].cnt == 0));
            chk($sformatf("v%0d_inready", i), 64'(inReady), 64'(v[i].cnt != 4));
            chk($sformatf("v%0d_regwrite", i), 64'(RegWrite), 64'(v[i].rw));
            chk($sformatf("v%0d_hit1", i), 64'(hit1), 64'(v[i].h1));
            chk($sformatf("v%0d_hitdata1", i), 64'(hitData1), 64'(v[i].d1));
            chk($sformatf("v%0d_hit2", i), 64'(hit2), 64'(v[i].h2));
            chk($sformatf("v%0d_hitdata2", i), 64'(hitData2), 64'(v[i].d2));
            tick();
        end

        // Fill, stall a fifth push, then drain in order with the stalled push slipping in.
        wbEnable = 1'b0;
        for (int r = 1; r <= 4; r++) push_one(5'(r), 32'h100 + 32'(r));
        inValid = 1'b1; inReg = 5'd9; inData = 32'h900;
        #1;
        chk("full_full", 64'(full), 1);
        chk("full_inready", 64'(inReady), 0);
        chk("full_count", 64'(count), 4);
        tick();
        chk("stall_count", 64'(count), 4);
        wbEnable = 1'b1;
        #1;
        chk("full_pop_rw", 64'(RegWrite), 1);
        tick();
        chk("after_pop_inready", 64'(inReady), 1);
        chk("after_pop_count", 64'(count), 3);
        tick();
        inValid = 1'b0;
        chk("stall_accept_count", 64'(count), 3);
        drain();

        // Concurrent push/pop around the ring for 3*DEPTH cycles.
        wbEnable = 1'b0;
        push_one(5'd10, 32'hA0);
        push_one(5'd11, 32'hB0);
        wbEnable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            inValid = 1'b1;
            inReg   = 5'(7 + i);
            inData  = (i == 0) ? 32'h77 : $urandom;
            #1;
            chk($sformatf("wrap%0d_count", i), 64'(count), 2);
            tick();
        end
        drain();

        // Asynchronous reset mid-cycle with three entries pending.
        wbEnable = 1'b0;
        push_one(5'd12, 32'hC12);
        push_one(5'd13, 32'hC13);
        push_one(5'd14, 32'hC14);
        wbEnable = 1'b1; lookupReg1 = 5'd12;
        #1;
        chk("pre_rst_rw", 64'(RegWrite), 1);
        chk("pre_rst_hit", 64'(hit1), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_rw", 64'(RegWrite), 0);
        chk("async_rst_count", 64'(count), 0);
        chk("async_rst_hit", 64'(hit1), 0);
        chk("async_rst_wdata", 64'(writeData), 0);
        chk("async_rst_inready", 64'(inReady), 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", 64'(empty), 1);

        // Synchronous flush with three entries pending.
        wbEnable = 1'b0;
        push_one(5'd20, 32'hD20);
        push_one(5'd21, 32'hD21);
        push_one(5'd22, 32'hD22);
        wbEnable = 1'b1; flush = 1'b1; lookupReg1 = 5'd21;
        #1;
        chk("flush_rw", 64'(RegWrite), 1);
        chk("flush_hit", 64'(hit1), 1);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_empty", 64'(empty), 1);
        chk("flush_count", 64'(count), 0);
        chk("flush_hit_after", 64'(hit1), 0);
        tick();
        tick();
        chk("flush_no_write", 64'(RegWrite), 0);
        chk("flush_sb", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Buffers pending register-file writes from the execute/memory stages.
- Issues pending writes to the register file one per cycle, in order, whenever the register file's write port is free.
- Provides a two-port lookup that returns the youngest pending value of a register, so read-side logic can forward data not yet committed to the register file.
- Sits between the result producers (ALU, load unit) and the register file's write port (writeReg, writeData, RegWrite).

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2
- ADDR_W, 5, register index width
- DATA_W, 32, register data width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all pending entries
- inValid  input  1  producer has a write request
- inReady  output  1  queue can accept a request this cycle
- inReg  input  ADDR_W  destination register of request
- inData  input  DATA_W  data of request
- wbEnable  input  1  register file write port is free this cycle
- RegWrite  output  1  write strobe to register file
- writeReg  output  ADDR_W  register index to write
- writeData  output  DATA_W  data to write
- lookupReg1  input  ADDR_W  first forwarding lookup index
- lookupReg2  input  ADDR_W  second forwarding lookup index
- hit1  output  1  lookupReg1 has a pending write
- hitData1  output  DATA_W  youngest pending data for lookupReg1
- hit2  output  1  lookupReg2 has a pending write
- hitData2  output  DATA_W  youngest pending data for lookupReg2
- count  output  $clog2(DEPTH)+1  number of valid entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0: head/tail pointers = 0, all entry valid bits = 0, count=0, empty=1, full=0, inReady=1.
  - RegWrite, hit1 and hit2 are 0 during reset; writeReg, writeData, hitData1 and hitData2 are 0.
  - Reset mid-operation discards all pending writes.
- Storage: circular buffer of DEPTH entries {reg, data}. Tail advances on push, head on pop; both wrap modulo DEPTH.
- Push:
  - inReady = !full. Registered-path timing: inReady does not depend on the same-cycle pop.
  - Handshake completes when inValid && inReady at a rising edge.
  - If inReg == 0 the handshake completes but nothing is enqueued, because register 0 is never written.
  - Otherwise the entry is written at the tail and count increments.
- Pop:
  - RegWrite = !empty && wbEnable (combinational).
  - writeReg and writeData = head entry when !empty, else 0.
  - On a rising edge with RegWrite=1, the head advances and count decrements.
  - Latency: an entry pushed at edge N is presented at edge N+1 at the earliest (when the queue was empty); no same-cycle bypass from in* to write*.
- Simultaneous push and pop: both occur, count is unchanged, and pointers advance independently. When full, pop frees a slot only for the next cycle.
- Order: writes commit strictly in acceptance order. Multiple pending writes to the same register are all issued; the last one wins in the register file.
- Lookup (combinational, per port):
  - Scans all valid entries; a hit requires a matching reg and a lookup index != 0.
  - hitData = data of the youngest matching entry (closest to tail).
  - On a miss, hit=0 and hitData=0.
  - The entry being popped this cycle still counts as a hit.
  - A request being pushed this cycle is not visible until the next cycle.
- Flush:
  - Synchronous; on a rising edge with flush=1, all entries are invalidated, pointers reset to 0 and count=0.
  - flush overrides a push and a pop in the same cycle; RegWrite is still combinationally asserted that cycle if !empty && wbEnable.
  - The producer must hold inValid low during flush.
- Invariant: count never exceeds DEPTH or underflows below 0; full and empty are never both 1.

Test Plan:
- Reset, then push {3, 0xA5A5A5A5} with wbEnable=0 -> count=1, RegWrite=0, lookupReg1=3 gives hit1=1, hitData1=0xA5A5A5A5. Raise wbEnable -> RegWrite=1, writeReg=3, writeData=0xA5A5A5A5 for one cycle, then empty=1.
- Push to reg 0 with data 0xFFFFFFFF -> inReady=1 and handshake completes, count stays 0; lookup of reg 0 gives hit=0.
- wbEnable=0, push regs 1,2,3,4 -> full=1, inReady=0; a fifth push stalls. Set wbEnable=1 -> writes issue 1,2,3,4 in order over 4 cycles, and the stalled push is accepted the cycle after the first pop.
- Push {5,0x11}, then {5,0x22} -> lookup 5 returns 0x22. After one pop, lookup still returns 0x22; after two pops, hit=0.
- Queue holds 2 entries, simultaneous push {7,0x77} and pop -> count stays 2, wrap-around is correct over 3×DEPTH operations, and the committed write sequence matches acceptance order.
- With 3 entries pending, assert rst_n=0 asynchronously mid-cycle -> RegWrite, count and hit drop to 0 immediately. Repeat with a synchronous flush -> empty=1 at the next edge, no further writes issued.
